// File: rtl/global_buffer_param.sv
// GLB core tunables and the write-port arbitration grant encoding.
package global_buffer_param;

  localparam int STRM_FIFO_DEPTH_DEF = 4;
  localparam int STALL_WIDTH_DEF     = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_STRM = 2'd1,
    GNT_PROC = 2'd2
  } gnt_t;

endpackage

// File: rtl/global_buffer_pkg.sv
// Shared GLB packet types: the bank write packet used by every write path.
package global_buffer_pkg;

  localparam int BANK_STRB_WIDTH = 8;
  localparam int BANK_ADDR_WIDTH = 16;
  localparam int BANK_DATA_WIDTH = 64;

  typedef struct packed {
    logic                       wr_en;
    logic [BANK_STRB_WIDTH-1:0] wr_strb;
    logic [BANK_ADDR_WIDTH-1:0] wr_addr;
    logic [BANK_DATA_WIDTH-1:0] wr_data;
  } wr_packet_t;

endpackage

// File: rtl/glb_sync_fifo.sv
// Single-clock FIFO, registered head, no write-to-read bypass.
// Push while full is accepted only when a pop happens in the same cycle.
module glb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_rd    = pop && !empty;
  assign do_wr    = push && (!full || do_rd);
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointer rollover is the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)      count <= count + CW'(1);
      else if (do_rd && !do_wr) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/glb_core_wr_arbiter.sv
// Arbitrates the GLB bank write port between buffered store-DMA writes and held
// processor writes; stream wins unless the processor has lost cfg_arb_max_stall times.
module glb_core_wr_arbiter
  import global_buffer_pkg::*;
  import global_buffer_param::*;
#(
  parameter int STRM_FIFO_DEPTH = STRM_FIFO_DEPTH_DEF,
  parameter int STALL_WIDTH     = STALL_WIDTH_DEF,
  localparam int CNT_W          = $clog2(STRM_FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  wr_packet_t             strm_wr_packet,
  input  wr_packet_t             proc_wr_packet,
  output logic                   proc_wr_rdy,
  output wr_packet_t             bank_wr_packet,
  input  logic [STALL_WIDTH-1:0] cfg_arb_max_stall,
  output logic [CNT_W-1:0]       strm_fifo_cnt,
  output logic                   strm_overflow_pulse
);

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  wr_packet_t             strm_head;
  logic                   hold_valid;
  wr_packet_t             hold_pkt;
  logic [STALL_WIDTH-1:0] stall_cnt;
  logic                   proc_accept;
  gnt_t                   gnt;

  assign fifo_push   = clk_en && strm_wr_packet.wr_en;
  assign fifo_pop    = clk_en && (gnt == GNT_STRM);
  assign proc_wr_rdy = !hold_valid;
  assign proc_accept = clk_en && proc_wr_packet.wr_en && !hold_valid;

  glb_sync_fifo #(
    .WIDTH ($bits(wr_packet_t)),
    .DEPTH (STRM_FIFO_DEPTH)
  ) u_strm_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (strm_wr_packet),
    .pop       (fifo_pop),
    .pop_data  (strm_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (strm_fifo_cnt)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (!fifo_empty && hold_valid)
      gnt = (stall_cnt >= cfg_arb_max_stall) ? GNT_PROC : GNT_STRM;
    else if (!fifo_empty)
      gnt = GNT_STRM;
    else if (hold_valid)
      gnt = GNT_PROC;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid          <= 1'b0;
      hold_pkt            <= '0;
      stall_cnt           <= '0;
      bank_wr_packet      <= '0;
      strm_overflow_pulse <= 1'b0;
    end else if (clk_en) begin
      // Accept and grant are exclusive: accept needs the hold register empty.
      if (proc_accept) begin
        hold_valid <= 1'b1;
        hold_pkt   <= proc_wr_packet;
      end else if (gnt == GNT_PROC) begin
        hold_valid <= 1'b0;
      end

      if (hold_valid && gnt != GNT_PROC) begin
        if (stall_cnt != {STALL_WIDTH{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
      end else begin
        stall_cnt <= '0;
      end

      unique case (gnt)
        GNT_STRM: bank_wr_packet <= strm_head;
        GNT_PROC: bank_wr_packet <= hold_pkt;
        default:  bank_wr_packet <= '0;
      endcase

      strm_overflow_pulse <= fifo_push && fifo_full && !fifo_pop;
    end
  end

endmodule

// File: tb/tb_glb_core_wr_arbiter.sv
// Directed vector table plus hand sequences for reset and clock-enable corner cases.
module tb_glb_core_wr_arbiter;
  import global_buffer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en;
  wr_packet_t strm_wr_packet;
  wr_packet_t proc_wr_packet;
  logic       proc_wr_rdy;
  wr_packet_t bank_wr_packet;
  logic [3:0] cfg_arb_max_stall;
  logic [2:0] strm_fifo_cnt;
  logic       strm_overflow_pulse;

  int n_chk  = 0;
  int n_fail = 0;

  glb_core_wr_arbiter #(.STRM_FIFO_DEPTH(4), .STALL_WIDTH(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .clk_en              (clk_en),
    .strm_wr_packet      (strm_wr_packet),
    .proc_wr_packet      (proc_wr_packet),
    .proc_wr_rdy         (proc_wr_rdy),
    .bank_wr_packet      (bank_wr_packet),
    .cfg_arb_max_stall   (cfg_arb_max_stall),
    .strm_fifo_cnt       (strm_fifo_cnt),
    .strm_overflow_pulse (strm_overflow_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s_en;
    logic [15:0] s_addr;
    logic        p_en;
    logic [15:0] p_addr;
    logic [3:0]  cfg;
    logic        e_en;
    logic [15:0] e_addr;
    int          e_cnt;
    logic        e_rdy;
    logic        e_ovf;
  } vec_t;

  vec_t vq[$];

  function automatic wr_packet_t mk_pkt(input logic [15:0] a);
    wr_packet_t p;
    p.wr_en   = 1'b1;
    p.wr_strb = a[7:0] ^ 8'hFF;
    p.wr_addr = a;
    p.wr_data = 64'hDEAD + {48'h0, a} - 64'h100;
    return p;
  endfunction

  task automatic add(input logic s_en, input logic [15:0] s_addr, input logic p_en,
                     input logic [15:0] p_addr, input logic [3:0] cfg, input logic e_en,
                     input logic [15:0] e_addr, input int e_cnt, input logic e_rdy,
                     input logic e_ovf);
    vec_t v;
    v.s_en = s_en; v.s_addr = s_addr; v.p_en = p_en; v.p_addr = p_addr; v.cfg = cfg;
    v.e_en = e_en; v.e_addr = e_addr; v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_ovf = e_ovf;
    vq.push_back(v);
  endtask

  task automatic set_in(input logic s_en, input logic [15:0] s_addr,
                        input logic p_en, input logic [15:0] p_addr);
    strm_wr_packet = s_en ? mk_pkt(s_addr) : '0;
    proc_wr_packet = p_en ? mk_pkt(p_addr) : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pkt(input string nm, input logic en, input logic [15:0] a);
    wr_packet_t exp;
    exp = en ? mk_pkt(a) : '0;
    n_chk++;
    if (bank_wr_packet !== exp) begin
      n_fail++;
      $display("FAIL %s: bank_wr_packet got %h expected %h", nm, bank_wr_packet, exp);
    end
  endtask

  task automatic chk_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic en, input logic [15:0] a,
                         input int cnt, input logic rdy, input logic ovf);
    chk_pkt({nm, " pkt"}, en, a);
    chk_val({nm, " cnt"}, 32'(strm_fifo_cnt), 32'(cnt));
    chk_val({nm, " rdy"}, 32'(proc_wr_rdy), 32'(rdy));
    chk_val({nm, " ovf"}, 32'(strm_overflow_pulse), 32'(ovf));
  endtask

  initial begin
    // Single stream write, then a single processor write.
    add(1, 16'h100, 0, 0, 3,  0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 3,        1, 16'h100, 0, 1, 0);
    add(0, 0, 0, 0, 3,        0, 0, 0, 1, 0);
    add(0, 0, 1, 16'h200, 3,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 3,        1, 16'h200, 0, 1, 0);
    add(0, 0, 0, 0, 3,        0, 0, 0, 1, 0);
    // cfg=3: processor loses 3 times then wins; stream order kept.
    add(1, 16'h300, 1, 16'h3F0, 3, 0, 0, 1, 0, 0);
    add(1, 16'h301, 0, 0, 3,  1, 16'h300, 1, 0, 0);
    add(1, 16'h302, 0, 0, 3,  1, 16'h301, 1, 0, 0);
    add(1, 16'h303, 0, 0, 3,  1, 16'h302, 1, 0, 0);
    add(1, 16'h304, 0, 0, 3,  1, 16'h3F0, 2, 1, 0);
    for (int i = 5; i < 10; i++)
      add(1, 16'h300 + 16'(i), 0, 0, 3, 1, 16'h300 + 16'(i - 2), 2, 1, 0);
    add(0, 0, 0, 0, 3,        1, 16'h308, 1, 1, 0);
    add(0, 0, 0, 0, 3,        1, 16'h309, 0, 1, 0);
    add(0, 0, 0, 0, 3,        0, 0, 0, 1, 0);
    // cfg=0 with continuous processor traffic: fill, full push+pop, overflow drop.
    add(1, 16'h400, 1, 16'h480, 0, 0, 0, 1, 0, 0);
    add(1, 16'h401, 1, 16'h481, 0, 1, 16'h480, 2, 1, 0);
    add(1, 16'h402, 1, 16'h482, 0, 1, 16'h400, 2, 0, 0);
    add(1, 16'h403, 1, 16'h483, 0, 1, 16'h482, 3, 1, 0);
    add(1, 16'h404, 1, 16'h484, 0, 1, 16'h401, 3, 0, 0);
    add(1, 16'h405, 1, 16'h485, 0, 1, 16'h484, 4, 1, 0);
    add(1, 16'h406, 1, 16'h486, 0, 1, 16'h402, 4, 0, 0);
    add(1, 16'h407, 1, 16'h487, 0, 1, 16'h486, 4, 1, 1);
    add(0, 0, 0, 0, 0,        1, 16'h403, 3, 1, 0);
    add(0, 0, 0, 0, 0,        1, 16'h404, 2, 1, 0);
    add(0, 0, 0, 0, 0,        1, 16'h405, 1, 1, 0);
    add(0, 0, 0, 0, 0,        1, 16'h406, 0, 1, 0);
    add(0, 0, 0, 0, 0,        0, 0, 0, 1, 0);

    reset = 1'b1;
    clk_en = 1'b1;
    cfg_arb_max_stall = 4'd3;
    set_in(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk_all("reset_state", 0, 0, 0, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      cfg_arb_max_stall = vq[i].cfg;
      set_in(vq[i].s_en, vq[i].s_addr, vq[i].p_en, vq[i].p_addr);
      tick();
      chk_all($sformatf("row%0d", i), vq[i].e_en, vq[i].e_addr, vq[i].e_cnt,
              vq[i].e_rdy, vq[i].e_ovf);
    end

    // Reset with 3 stream entries and a held processor write.
    cfg_arb_max_stall = 4'd0;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 16'h500 + 16'(i), 1, 16'h580 + 16'(i));
      tick();
    end
    chk_val("pre_reset cnt", 32'(strm_fifo_cnt), 32'd3);
    chk_val("pre_reset rdy", 32'(proc_wr_rdy), 32'd0);
    set_in(0, 0, 0, 0);
    reset = 1'b1;
    #2 chk_all("in_reset", 0, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all($sformatf("post_reset%0d", i), 0, 0, 0, 1, 0);
    end

    // clk_en low for 5 cycles mid-stream; inputs presented then are ignored.
    cfg_arb_max_stall = 4'd3;
    set_in(1, 16'h600, 0, 0); tick(); chk_all("ce_a", 0, 0, 1, 1, 0);
    set_in(1, 16'h601, 0, 0); tick(); chk_all("ce_b", 1, 16'h600, 1, 1, 0);
    set_in(1, 16'h602, 0, 0); tick(); chk_all("ce_c", 1, 16'h601, 1, 1, 0);
    clk_en = 1'b0;
    set_in(1, 16'h6AA, 1, 16'h6BB);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all($sformatf("ce_frozen%0d", i), 1, 16'h601, 1, 1, 0);
    end
    clk_en = 1'b1;
    set_in(0, 0, 0, 0);
    tick(); chk_all("ce_resume0", 1, 16'h602, 0, 1, 0);
    tick(); chk_all("ce_resume1", 0, 0, 0, 1, 0);
    tick(); chk_all("ce_resume2", 0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
